// File: rtl/bitbal_pkg.sv
// Shared types and helpers for the bit_balance_accum streaming ones/disparity counter.
package bitbal_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } bitbal_state_e;

  // Top two bits of a one-bit-wider signed sum: 01 is positive overflow, 10 negative.
  localparam logic [1:0] DISP_SAT_POS = 2'b01;
  localparam logic [1:0] DISP_SAT_NEG = 2'b10;

  function automatic int bitbal_clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bitbal_popcount.sv
// Combinational population count of one DATA_W-bit beat.
module bitbal_popcount
  import bitbal_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = bitbal_clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_W; i++) begin
      count = count + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/bit_balance_accum.sv
// Per-frame ones/beats/disparity accumulator with valid/ready on both sides.
// Optional BITBAL_RUNNING_DISP_EN adds a saturating cross-frame disparity output run_disp.
module bit_balance_accum
  import bitbal_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  parameter int TOL       = 0,
  parameter int ACC_W     = bitbal_clog2(DATA_W * MAX_BEATS + 1),
  parameter int BEAT_W    = bitbal_clog2(MAX_BEATS + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        out_ones,
  output logic [BEAT_W-1:0]       out_beats,
  output logic signed [ACC_W:0]   out_disp,
  output logic                    out_balanced,
  output logic                    out_trunc
`ifdef BITBAL_RUNNING_DISP_EN
  ,
  output logic signed [ACC_W:0]   run_disp
`endif
);

  localparam int CNT_W = bitbal_clog2(DATA_W + 1);
  localparam int DW    = ACC_W + 2;
  localparam int CW    = (ACC_W + 1 > 32) ? ACC_W + 1 : 32;

  bitbal_state_e state_q, state_d;

  logic [ACC_W-1:0]  acc_ones_q, acc_ones_d;
  logic [BEAT_W-1:0] acc_beats_q, acc_beats_d;

  logic [ACC_W-1:0]  out_ones_q, out_ones_d;
  logic [BEAT_W-1:0] out_beats_q, out_beats_d;
  logic [ACC_W:0]    out_disp_q, out_disp_d;
  logic              out_balanced_q, out_balanced_d;
  logic              out_trunc_q, out_trunc_d;

  logic [CNT_W-1:0]  beat_ones;
  logic              accept;
  logic              close;
  logic [ACC_W-1:0]  sum_ones;
  logic [BEAT_W-1:0] sum_beats;
  logic [DW-1:0]     frame_diff;
  logic [ACC_W:0]    frame_disp;
  logic [ACC_W:0]    disp_mag;
  logic              frame_balanced;

  bitbal_popcount #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) u_popcount (
    .data (in_data),
    .count(beat_ones)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if (close) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready && !close) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    out_valid = (state_q == HOLD);
    in_ready  = (state_q == ACCUM) || out_ready;
  end

  // Frame totals include the beat being accepted this cycle, so a closing beat lands in its own frame.
  always_comb begin
    accept     = in_valid && in_ready;
    sum_ones   = acc_ones_q + ACC_W'(beat_ones);
    sum_beats  = acc_beats_q + BEAT_W'(1);
    close      = accept && (in_last || (sum_beats == BEAT_W'(MAX_BEATS)));
    frame_diff = DW'({sum_ones, 1'b0}) - (DW'(DATA_W) * DW'(sum_beats));
    frame_disp = frame_diff[ACC_W:0];
    disp_mag   = frame_disp[ACC_W] ? (~frame_disp + 1'b1) : frame_disp;
    frame_balanced = (CW'(disp_mag) <= CW'(TOL));
  end

  always_comb begin
    acc_ones_d     = acc_ones_q;
    acc_beats_d    = acc_beats_q;
    out_ones_d     = out_ones_q;
    out_beats_d    = out_beats_q;
    out_disp_d     = out_disp_q;
    out_balanced_d = out_balanced_q;
    out_trunc_d    = out_trunc_q;
    if (close) begin
      acc_ones_d     = '0;
      acc_beats_d    = '0;
      out_ones_d     = sum_ones;
      out_beats_d    = sum_beats;
      out_disp_d     = frame_disp;
      out_balanced_d = frame_balanced;
      out_trunc_d    = !in_last;
    end else if (accept) begin
      acc_ones_d  = sum_ones;
      acc_beats_d = sum_beats;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_ones_q     <= '0;
      acc_beats_q    <= '0;
      out_ones_q     <= '0;
      out_beats_q    <= '0;
      out_disp_q     <= '0;
      out_balanced_q <= 1'b0;
      out_trunc_q    <= 1'b0;
    end else begin
      acc_ones_q     <= acc_ones_d;
      acc_beats_q    <= acc_beats_d;
      out_ones_q     <= out_ones_d;
      out_beats_q    <= out_beats_d;
      out_disp_q     <= out_disp_d;
      out_balanced_q <= out_balanced_d;
      out_trunc_q    <= out_trunc_d;
    end
  end

  assign out_ones     = out_ones_q;
  assign out_beats    = out_beats_q;
  assign out_disp     = out_disp_q;
  assign out_balanced = out_balanced_q;
  assign out_trunc    = out_trunc_q;

`ifdef BITBAL_RUNNING_DISP_EN
  logic [ACC_W:0] run_disp_q, run_disp_d;
  logic [DW-1:0]  beat_disp;
  logic [DW-1:0]  run_sum;

  // Sum is one bit wider than the register; the top two bits disagreeing means overflow.
  always_comb begin
    beat_disp  = DW'({beat_ones, 1'b0}) - DW'(DATA_W);
    run_sum    = {run_disp_q[ACC_W], run_disp_q} + beat_disp;
    run_disp_d = run_disp_q;
    if (accept) begin
      case (run_sum[DW-1:DW-2])
        DISP_SAT_POS: run_disp_d = {1'b0, {ACC_W{1'b1}}};
        DISP_SAT_NEG: run_disp_d = {1'b1, {ACC_W{1'b0}}};
        default:      run_disp_d = run_sum[ACC_W:0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_disp_q <= '0;
    end else begin
      run_disp_q <= run_disp_d;
    end
  end

  assign run_disp = run_disp_q;
`endif

endmodule
